// File: rtl/d_mem_pipe_pkg.sv
// d_mem_pipe_pkg: shared types and helpers for the pipelined data memory.
// The response stage struct is sized for the widest supported DATA_W (64);
// narrower instances carry the result zero-extended and slice it on output.
// The err field exists only when D_MEM_PIPE_ERR_EN is defined.
package d_mem_pipe_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } sz_e;

  localparam int unsigned MAX_DATA_W = 64;

  typedef struct packed {
    logic                  valid;
`ifdef D_MEM_PIPE_ERR_EN
    logic                  err;
`endif
    logic [MAX_DATA_W-1:0] rdata;
  } rsp_stage_t;

  // Byte enables for an access of 2^size bytes starting at byte lane off.
  function automatic logic [7:0] calc_be(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << size)) - 16'd1;
    return 8'(m << off);
  endfunction

endpackage

// File: rtl/d_mem_pipe_if.sv
// d_mem_pipe_if: request/response handshake bundle for d_mem_pipe.
// master = requester (core load/store unit), slave = the memory.
interface d_mem_pipe_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/d_mem_rsp_pipe.sv
// d_mem_rsp_pipe: RD_LAT-deep response shift chain. The whole chain holds
// while the last stage is valid and the consumer is not ready; bubbles never
// cause a hold.
module d_mem_rsp_pipe
  import d_mem_pipe_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  rsp_stage_t i_stage,
  input  logic       i_rsp_ready,
  output rsp_stage_t o_stage,
  output logic       o_stall
);

  rsp_stage_t r_stage [RD_LAT];

  assign o_stage = r_stage[RD_LAT-1];
  assign o_stall = r_stage[RD_LAT-1].valid && !i_rsp_ready;

  // advance every stage together unless the output is back-pressured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_stage[i] <= '0;
    end else if (!o_stall) begin
      r_stage[0] <= i_stage;
      for (int i = 1; i < RD_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

endmodule

// File: rtl/d_mem_pipe.sv
// d_mem_pipe: pipelined byte-addressed data memory with lane steering and
// load extension. Optional macro D_MEM_PIPE_ERR_EN enables error reporting
// for misaligned, oversize and out-of-range accesses; without it such
// accesses are aligned down, clamped to full width and wrapped modulo DEPTH.
module d_mem_pipe
  import d_mem_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input logic         clk,
  input logic         rst_n,
  d_mem_pipe_if.slave bus
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned IDXF_W = ADDR_W - OFF_W;
  localparam int unsigned SEL_W  = $clog2(DATA_W);
  localparam sz_e         SZ_FULL = (DATA_W == 64) ? SZ_D : SZ_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_stall;
  logic              w_accept;
  logic              w_err;
  logic              w_bad_size;
  logic              w_sign;
  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_off_mask;
  logic [OFF_W-1:0]  w_off_al;
  logic [IDXF_W-1:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_size_eff;
  logic [BYTES-1:0]  w_be;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [DATA_W-1:0] w_rword;
  logic [DATA_W-1:0] w_rword_sh;
  logic [DATA_W-1:0] w_ldata;
  rsp_stage_t        w_in_stage;
  rsp_stage_t        w_out_stage;

  assign bus.req_ready = !w_stall;
  assign w_accept      = bus.req_valid && !w_stall;

  assign w_off      = OFF_W'(bus.req_addr);
  assign w_idx_full = IDXF_W'(bus.req_addr >> OFF_W);
  assign w_idx      = IDX_W'(w_idx_full);
  assign w_bad_size = bus.req_size > SZ_FULL;
  assign w_size_eff = w_bad_size ? SZ_FULL : bus.req_size;
  assign w_off_mask = OFF_W'((1 << w_size_eff) - 1);
  assign w_off_al   = w_off & ~w_off_mask;
  assign w_be       = BYTES'(calc_be(w_size_eff, 3'(w_off_al)));

`ifdef D_MEM_PIPE_ERR_EN
  assign w_err = w_bad_size || ((w_off & w_off_mask) != '0) || ((w_idx_full >> IDX_W) != '0);
`else
  assign w_err = 1'b0;
`endif

  assign w_wdata_sh = bus.req_wdata << {w_off_al, 3'b000};

  // byte-enabled store; the array has no reset so committed data survives rst_n
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && bus.req_we && !w_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
      end
    end
  end

  assign w_rword    = r_mem[w_idx];
  assign w_rword_sh = w_rword >> {w_off_al, 3'b000};
  assign w_sign     = w_rword_sh[SEL_W'((8 << w_size_eff) - 1)];

  // keep the low 2^size bytes and fill the rest with sign or zero
  always_comb begin
    w_ldata = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (b < (1 << w_size_eff)) w_ldata[b*8 +: 8] = w_rword_sh[b*8 +: 8];
      else                       w_ldata[b*8 +: 8] = {8{w_sign && !bus.req_unsigned}};
    end
  end

  // build the stage entry: stores and erroring loads return zero data
  always_comb begin
    w_in_stage       = '0;
    w_in_stage.valid = w_accept;
    if (!bus.req_we && !w_err) w_in_stage.rdata = MAX_DATA_W'(w_ldata);
`ifdef D_MEM_PIPE_ERR_EN
    w_in_stage.err   = w_err;
`endif
  end

  d_mem_rsp_pipe #(.RD_LAT(RD_LAT)) u_rsp_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_stage     (w_in_stage),
    .i_rsp_ready (bus.rsp_ready),
    .o_stage     (w_out_stage),
    .o_stall     (w_stall)
  );

  assign bus.rsp_valid = w_out_stage.valid;
  assign bus.rsp_rdata = DATA_W'(w_out_stage.rdata);
`ifdef D_MEM_PIPE_ERR_EN
  assign bus.rsp_err   = w_out_stage.err;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule
